// File: rtl/spi_arbiter_pkg.sv
// Shared constants for the SPI request arbiter: operation codes and FSM states.
package spi_arbiter_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_EOT = 2'd2,
    ST_COMPLETE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request after i_last wins.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scan last+1, last+2, ... last+N (mod N); the last slot checked is i_last itself.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!o_valid && i_req[(int'(i_last) + k) % NUM_REQ]) begin
        o_valid                                   = 1'b1;
        o_onehot[(int'(i_last) + k) % NUM_REQ]    = 1'b1;
        o_idx                                     = IDX_W'((int'(i_last) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/spi_request_arbiter.sv
// Round-robin sharing of one quick_spi master between NUM_REQUESTERS clients.
// One transaction at a time; a watchdog aborts a transaction whose EOT never comes.
module spi_request_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS      = 4,
  parameter int INCOMING_DATA_WIDTH = 8,
  parameter int OUTGOING_DATA_WIDTH = 16,
  parameter int NUMBER_OF_SLAVES    = 2,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [NUM_REQUESTERS-1:0]                     req,
  input  logic [NUM_REQUESTERS-1:0]                     req_operation,
  input  logic [NUM_REQUESTERS*NUMBER_OF_SLAVES-1:0]    req_slave,
  input  logic [NUM_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_outgoing_data,
  output logic [NUM_REQUESTERS-1:0]                     grant,
  output logic [NUM_REQUESTERS-1:0]                     done,
  output logic [INCOMING_DATA_WIDTH-1:0]                rd_data,
  output logic                                          timeout_err,
  output logic                                          spi_start_transaction,
  output logic                                          spi_operation,
  output logic [NUMBER_OF_SLAVES-1:0]                   spi_slave,
  output logic [OUTGOING_DATA_WIDTH-1:0]                spi_outgoing_data,
  input  logic                                          spi_end_of_transaction,
  input  logic [INCOMING_DATA_WIDTH-1:0]                spi_incoming_data
);

  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  arb_state_t                      r_state, w_state_nxt;
  logic [IDX_W-1:0]                r_last, r_idx;
  logic [WD_W-1:0]                 r_wdog;
  logic [NUM_REQUESTERS-1:0]       r_grant, r_done;
  logic [INCOMING_DATA_WIDTH-1:0]  r_rd_data;
  logic                            r_timeout_err, r_start, r_op;
  logic [NUMBER_OF_SLAVES-1:0]     r_slave;
  logic [OUTGOING_DATA_WIDTH-1:0]  r_payload;

  logic [NUM_REQUESTERS-1:0]       w_win_onehot;
  logic [IDX_W-1:0]                w_win_idx;
  logic                            w_win_valid;
  logic                            w_wdog_expire;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQUESTERS),
    .IDX_W   (IDX_W)
  ) u_picker (
    .i_req    (req),
    .i_last   (r_last),
    .o_onehot (w_win_onehot),
    .o_idx    (w_win_idx),
    .o_valid  (w_win_valid)
  );

  assign w_wdog_expire = (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state. EOT is only looked at in WAIT_EOT and COMPLETE, so an EOT
  // left high from a previous transaction cannot complete a new one early.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_win_valid) w_state_nxt = ST_ISSUE;
      ST_ISSUE:    w_state_nxt = ST_WAIT_EOT;
      ST_WAIT_EOT: if (spi_end_of_transaction || w_wdog_expire) w_state_nxt = ST_COMPLETE;
      ST_COMPLETE: if (!spi_end_of_transaction) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, latched request fields, watchdog and rr pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant       <= '0;
      r_done        <= '0;
      r_rd_data     <= '0;
      r_timeout_err <= 1'b0;
      r_start       <= 1'b0;
      r_op          <= 1'b0;
      r_slave       <= '0;
      r_payload     <= '0;
      r_idx         <= '0;
      r_last        <= IDX_W'(NUM_REQUESTERS - 1);
      r_wdog        <= '0;
    end else begin
      r_start       <= 1'b0;
      r_done        <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_grant   <= w_win_onehot;
            r_idx     <= w_win_idx;
            r_op      <= req_operation[w_win_idx];
            r_slave   <= req_slave[int'(w_win_idx)*NUMBER_OF_SLAVES +: NUMBER_OF_SLAVES];
            r_payload <= req_outgoing_data[int'(w_win_idx)*OUTGOING_DATA_WIDTH +: OUTGOING_DATA_WIDTH];
          end
        end
        ST_ISSUE: begin
          r_start <= 1'b1;
          r_wdog  <= '0;
        end
        ST_WAIT_EOT: begin
          if (spi_end_of_transaction) begin
            if (r_op == OP_READ) r_rd_data <= spi_incoming_data;
            r_done <= r_grant;
            r_last <= r_idx;
          end else if (w_wdog_expire) begin
            r_rd_data     <= '0;
            r_timeout_err <= 1'b1;
            r_done        <= r_grant;
            r_last        <= r_idx;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_COMPLETE: begin
          if (!spi_end_of_transaction) r_grant <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant                 = r_grant;
  assign done                  = r_done;
  assign rd_data               = r_rd_data;
  assign timeout_err           = r_timeout_err;
  assign spi_start_transaction = r_start;
  assign spi_operation         = r_op;
  assign spi_slave             = r_slave;
  assign spi_outgoing_data     = r_payload;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Directed bench for spi_request_arbiter; the bench plays the role of the SPI core.
module tb_spi_request_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req_operation;
  logic [7:0]  req_slave;
  logic [63:0] req_outgoing_data;
  logic [3:0]  grant, done;
  logic [7:0]  rd_data;
  logic        timeout_err, spi_start_transaction, spi_operation;
  logic [1:0]  spi_slave;
  logic [15:0] spi_outgoing_data;
  logic        eot;
  logic [7:0]  inc;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ovl_cnt = 0;

  spi_request_arbiter dut (
    .clk                    (clk),
    .reset                  (reset),
    .req                    (req),
    .req_operation          (req_operation),
    .req_slave              (req_slave),
    .req_outgoing_data      (req_outgoing_data),
    .grant                  (grant),
    .done                   (done),
    .rd_data                (rd_data),
    .timeout_err            (timeout_err),
    .spi_start_transaction  (spi_start_transaction),
    .spi_operation          (spi_operation),
    .spi_slave              (spi_slave),
    .spi_outgoing_data      (spi_outgoing_data),
    .spi_end_of_transaction (eot),
    .spi_incoming_data      (inc)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!reset && !$onehot0(grant)) ovl_cnt++;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Serves one transaction as the SPI core and reports what was observed.
  task automatic run_txn(input int delay, input bit no_eot, input logic [7:0] din,
                         input int hold, input bit mutate,
                         output logic [3:0] g, output logic [15:0] pay, output int starts,
                         output int ticks, output logic [3:0] d, output logic to,
                         output logic [7:0] rdv, output int extra_done, output bit held,
                         output logic [3:0] g_after, output bit stable);
    g = '0; pay = '0; starts = 0; ticks = 0; d = '0; to = 1'b0; rdv = '0;
    extra_done = 0; held = 1'b1; g_after = '0; stable = 1'b1;
    for (int w = 0; w < 20 && grant == 4'b0; w++) tick();
    g = grant;
    pay = spi_outgoing_data;
    if (g == 4'b0) return;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      if (!no_eot && cyc == delay) begin eot = 1'b1; inc = din; end
      tick();
      ticks++;
      if (spi_start_transaction) starts++;
      if (spi_outgoing_data !== pay) stable = 1'b0;
      if (cyc == 0 && mutate) begin
        req = 4'b0;
        req_outgoing_data = {4{16'h1234}};
      end
      if (done != 4'b0) break;
    end
    d = done; to = timeout_err; rdv = rd_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (done != 4'b0) extra_done++;
      if (grant == 4'b0) held = 1'b0;
      if (spi_start_transaction) starts++;
      if (spi_outgoing_data !== pay) stable = 1'b0;
    end
    eot = 1'b0;
    tick();
    g_after = grant;
    if (done != 4'b0) extra_done++;
    if (spi_start_transaction) starts++;
    if (spi_outgoing_data !== pay) stable = 1'b0;
  endtask

  logic [3:0]  g, d, ga;
  logic [15:0] pay;
  logic [7:0]  rdv;
  logic        to;
  int          starts, ticks, xd;
  bit          held, stab;

  task automatic test_reset();
    reset = 1'b1; req = 4'hF; req_operation = 4'hF; req_slave = 8'h00;
    for (int i = 0; i < 4; i++) req_outgoing_data[i*16 +: 16] = 16'hC0D0 + 16'(i);
    eot = 1'b0; inc = 8'h00;
    tick(); tick(); tick();
    total_cnt++;
    if ({grant, done, rd_data, timeout_err, spi_start_transaction, spi_operation,
         spi_slave, spi_outgoing_data} !== 35'b0)
      $display("FAIL reset_values: grant=%b done=%b rd=%h to=%b st=%b op=%b sl=%b pay=%h want all 0",
               grant, done, rd_data, timeout_err, spi_start_transaction, spi_operation,
               spi_slave, spi_outgoing_data);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [3:0] eg;
    reset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      eg = 4'b0001 << exp_seq[t];
      run_txn(2, 1'b0, 8'h00, 0, 1'b0, g, pay, starts, ticks, d, to, rdv, xd, held, ga, stab);
      total_cnt++;
      if (g !== eg) $display("FAIL rr_grant%0d: got %b want %b", t, g, eg); else pass_cnt++;
      total_cnt++;
      if (pay !== 16'hC0D0 + 16'(exp_seq[t]))
        $display("FAIL rr_payload%0d: got %h want %h", t, pay, 16'hC0D0 + 16'(exp_seq[t]));
      else pass_cnt++;
      total_cnt++;
      if (starts !== 1 || d !== eg)
        $display("FAIL rr_start_done%0d: starts=%0d done=%b want 1 and %b", t, starts, d, eg);
      else pass_cnt++;
    end
    req = 4'b0;
    total_cnt++;
    if (ovl_cnt !== 0) $display("FAIL rr_overlap: %0d cycles non-onehot grant, want 0", ovl_cnt);
    else pass_cnt++;
  endtask

  task automatic test_read();
    req_operation[2] = 1'b0; req_slave[5:4] = 2'b01; req = 4'b0100;
    run_txn(40, 1'b0, 8'hA5, 0, 1'b0, g, pay, starts, ticks, d, to, rdv, xd, held, ga, stab);
    req = 4'b0;
    total_cnt++;
    if (g !== 4'b0100 || spi_slave !== 2'b01 || spi_operation !== 1'b0)
      $display("FAIL read_grant: grant=%b slave=%b op=%b want 0100 01 0", g, spi_slave, spi_operation);
    else pass_cnt++;
    total_cnt++;
    if (d !== 4'b0100 || rdv !== 8'hA5 || to !== 1'b0)
      $display("FAIL read_done: done=%b rd=%h to=%b want 0100 a5 0", d, rdv, to);
    else pass_cnt++;
    total_cnt++;
    if (ticks !== 41 || xd !== 0 || ga !== 4'b0)
      $display("FAIL read_timing: ticks=%0d extra_done=%0d grant_after=%b want 41 0 0000", ticks, xd, ga);
    else pass_cnt++;
  endtask

  task automatic test_write();
    req_operation[1] = 1'b1; req_outgoing_data[31:16] = 16'hBEEF; req = 4'b0010;
    run_txn(5, 1'b0, 8'h77, 0, 1'b1, g, pay, starts, ticks, d, to, rdv, xd, held, ga, stab);
    total_cnt++;
    if (g !== 4'b0010 || pay !== 16'hBEEF || stab !== 1'b1)
      $display("FAIL write_payload: grant=%b pay=%h stable=%b want 0010 beef 1", g, pay, stab);
    else pass_cnt++;
    total_cnt++;
    if (d !== 4'b0010 || rdv !== 8'hA5)
      $display("FAIL write_done: done=%b rd=%h want 0010 a5", d, rdv);
    else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++;
    if (grant !== 4'b0) $display("FAIL write_no_regrant: grant=%b want 0000", grant); else pass_cnt++;
  endtask

  task automatic test_timeout();
    req_operation[3] = 1'b0; req_operation[0] = 1'b1; req = 4'b1001;
    run_txn(0, 1'b1, 8'h00, 0, 1'b0, g, pay, starts, ticks, d, to, rdv, xd, held, ga, stab);
    req = 4'b0001;
    total_cnt++;
    if (g !== 4'b1000 || ticks !== 1025)
      $display("FAIL timeout_latency: grant=%b ticks=%0d want 1000 1025", g, ticks);
    else pass_cnt++;
    total_cnt++;
    if (d !== 4'b1000 || to !== 1'b1 || rdv !== 8'h00)
      $display("FAIL timeout_done: done=%b to=%b rd=%h want 1000 1 00", d, to, rdv);
    else pass_cnt++;
    total_cnt++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_pulse: to=%b want 0", timeout_err); else pass_cnt++;
    run_txn(2, 1'b0, 8'h00, 0, 1'b0, g, pay, starts, ticks, d, to, rdv, xd, held, ga, stab);
    req = 4'b0;
    total_cnt++;
    if (g !== 4'b0001 || d !== 4'b0001 || to !== 1'b0)
      $display("FAIL timeout_next: grant=%b done=%b to=%b want 0001 0001 0", g, d, to);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    req_operation[0] = 1'b0; req = 4'b0001;
    run_txn(3, 1'b0, 8'h3C, 0, 1'b0, g, pay, starts, ticks, d, to, rdv, xd, held, ga, stab);
    total_cnt++;
    if (d !== 4'b0001 || rdv !== 8'h3C || ga !== 4'b0)
      $display("FAIL b2b_first: done=%b rd=%h grant_after=%b want 0001 3c 0000", d, rdv, ga);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (grant !== 4'b0001) $display("FAIL b2b_regrant: grant=%b want 0001", grant); else pass_cnt++;
    run_txn(2, 1'b0, 8'h5A, 0, 1'b0, g, pay, starts, ticks, d, to, rdv, xd, held, ga, stab);
    req = 4'b0;
    total_cnt++;
    if (d !== 4'b0001 || rdv !== 8'h5A || starts !== 1)
      $display("FAIL b2b_second: done=%b rd=%h starts=%0d want 0001 5a 1", d, rdv, starts);
    else pass_cnt++;
  endtask

  task automatic test_eot_in_issue();
    req_operation[2] = 1'b1; req = 4'b0100;
    run_txn(0, 1'b0, 8'hEE, 0, 1'b1, g, pay, starts, ticks, d, to, rdv, xd, held, ga, stab);
    total_cnt++;
    if (ticks !== 2 || starts !== 1 || d !== 4'b0100 || rdv !== 8'h5A)
      $display("FAIL eot_in_issue: ticks=%0d starts=%0d done=%b rd=%h want 2 1 0100 5a",
               ticks, starts, d, rdv);
    else pass_cnt++;
  endtask

  task automatic test_eot_hold();
    req_operation[1] = 1'b1; req = 4'b0010;
    run_txn(3, 1'b0, 8'h11, 4, 1'b1, g, pay, starts, ticks, d, to, rdv, xd, held, ga, stab);
    total_cnt++;
    if (d !== 4'b0010 || xd !== 0)
      $display("FAIL eot_hold_done: done=%b extra_done=%0d want 0010 0", d, xd);
    else pass_cnt++;
    total_cnt++;
    if (held !== 1'b1 || ga !== 4'b0 || starts !== 1)
      $display("FAIL eot_hold_complete: held=%b grant_after=%b starts=%0d want 1 0000 1", held, ga, starts);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    req_operation[0] = 1'b0; req_slave[1:0] = 2'b11; req = 4'b0001;
    for (int w = 0; w < 20 && grant == 4'b0; w++) tick();
    tick(); tick(); tick();
    total_cnt++;
    if (grant !== 4'b0001 || spi_slave !== 2'b11)
      $display("FAIL mid_pre: grant=%b slave=%b want 0001 11", grant, spi_slave);
    else pass_cnt++;
    reset = 1'b1; req = 4'hF;
    #1;
    total_cnt++;
    if ({grant, done, rd_data, timeout_err, spi_start_transaction, spi_operation,
         spi_slave, spi_outgoing_data} !== 35'b0)
      $display("FAIL mid_reset: grant=%b done=%b rd=%h to=%b st=%b op=%b sl=%b pay=%h want all 0",
               grant, done, rd_data, timeout_err, spi_start_transaction, spi_operation,
               spi_slave, spi_outgoing_data);
    else pass_cnt++;
    tick(); tick();
    reset = 1'b0;
    for (int w = 0; w < 20 && grant == 4'b0; w++) tick();
    total_cnt++;
    if (grant !== 4'b0001) $display("FAIL mid_first_grant: grant=%b want 0001", grant); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_write();
    test_timeout();
    test_back_to_back();
    test_eot_in_issue();
    test_eot_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
